// File: rtl/program_sequencer_pkg.sv
// Shared constants for the gamma program sequencer: op classes, FSM states,
// the UPDATE-path control bundle and the retired-count width default.
package gamma_ctrl_pkg;

   localparam int CNT_W_DEF = 16;

   typedef enum logic [2:0] {
      OP_ALU  = 3'd0,
      OP_BR   = 3'd1,
      OP_BRC  = 3'd2,
      OP_JR   = 3'd3,
      OP_CALL = 3'd4,
      OP_HALT = 3'd7
   } op_class_e;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_UPDATE = 3'd3,
      S_HALT   = 3'd4
   } state_e;

   typedef struct packed {
      logic pc_select;
      logic inc_select;
      logic link_we;
   } pc_ctrl_t;

   function automatic logic is_halt(input logic [2:0] cls);
      return cls == OP_HALT;
   endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Bundle between the sequencer, instruction memory, decoder and PC datapath.
// master = sequencer side, slave = environment side.
interface program_sequencer_if
   import gamma_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
);

   logic             Start;
   logic             Mem_ready;
   logic [2:0]       Op_class;
   logic             Cond_true;
   logic             Mem_req;
   logic             IR_load;
   logic             PC_Reset;
   logic             PC_enable;
   logic             PC_select;
   logic             INC_select;
   logic             Link_we;
   logic             Halted;
   logic [CNT_W-1:0] Inst_count;

   modport master (
      input  Start,
      input  Mem_ready,
      input  Op_class,
      input  Cond_true,
      output Mem_req,
      output IR_load,
      output PC_Reset,
      output PC_enable,
      output PC_select,
      output INC_select,
      output Link_we,
      output Halted,
      output Inst_count
   );

   modport slave (
      output Start,
      output Mem_ready,
      output Op_class,
      output Cond_true,
      input  Mem_req,
      input  IR_load,
      input  PC_Reset,
      input  PC_enable,
      input  PC_select,
      input  INC_select,
      input  Link_we,
      input  Halted,
      input  Inst_count
   );

endinterface

// File: rtl/program_sequencer_decode.sv
// pc_ctrl_decode: registered class + condition -> {PC_select, INC_select, Link_we}.
// Link pulse on CALL only with PROGRAM_SEQUENCER_LINK_EN; otherwise CALL == BR.
module pc_ctrl_decode
   import gamma_ctrl_pkg::*;
(
   input  logic [2:0] op_class,
   input  logic       cond,
   output pc_ctrl_t   ctrl
);

   // Classes 5, 6 and anything unlisted fall through to the ALU (PC+1) map.
   always_comb begin
      ctrl.pc_select  = 1'b1;
      ctrl.inc_select = 1'b0;
      ctrl.link_we    = 1'b0;
      unique case (1'b1)
         (op_class == OP_BR): begin
            ctrl.inc_select = 1'b1;
         end
         (op_class == OP_BRC): begin
            ctrl.inc_select = cond;
         end
         (op_class == OP_JR): begin
            ctrl.pc_select = 1'b0;
         end
         (op_class == OP_CALL): begin
            ctrl.inc_select = 1'b1;
`ifdef PROGRAM_SEQUENCER_LINK_EN
            ctrl.link_we = 1'b1;
`else
            ctrl.link_we = 1'b0;
`endif
         end
         default: begin
            ctrl.pc_select = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/program_sequencer.sv
// program_sequencer: IDLE/FETCH/DECODE/UPDATE/HALT controller, sole PC writer.
// Optional CALL link strobe: define PROGRAM_SEQUENCER_LINK_EN.
module program_sequencer
   import gamma_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
)(
   input logic                  Clock,
   input logic                  Reset,
   program_sequencer_if.master  bus
);

   state_e           state;
   state_e           state_nxt;
   logic [2:0]       op_q;
   logic             cond_q;
   logic [CNT_W-1:0] cnt_q;
   pc_ctrl_t         dec;

   logic mem_req;
   logic ir_load;
   logic pc_reset;
   logic pc_enable;
   logic pc_select;
   logic inc_select;
   logic link_we;
   logic halted;

   pc_ctrl_decode u_decode (
      .op_class (op_q),
      .cond     (cond_q),
      .ctrl     (dec)
   );

   // State register; reset returns to IDLE from anywhere, beating Start.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Class/condition captured in DECODE only; counter retires in UPDATE.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         op_q   <= OP_ALU;
         cond_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         if (state == S_DECODE) begin
            op_q   <= bus.Op_class;
            cond_q <= bus.Cond_true;
         end
         if (state == S_UPDATE) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   // Next state and strobes; selects are forced low outside UPDATE.
   always_comb begin
      state_nxt  = state;
      mem_req    = 1'b0;
      ir_load    = 1'b0;
      pc_reset   = 1'b0;
      pc_enable  = 1'b0;
      pc_select  = 1'b0;
      inc_select = 1'b0;
      link_we    = 1'b0;
      halted     = 1'b0;
      unique case (state)
         S_IDLE: begin
            pc_reset = 1'b1;
            if (bus.Start) begin
               state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            mem_req = 1'b1;
            ir_load = bus.Mem_ready;
            if (bus.Mem_ready) begin
               state_nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            if (is_halt(bus.Op_class)) begin
               state_nxt = S_HALT;
            end else begin
               state_nxt = S_UPDATE;
            end
         end
         S_UPDATE: begin
            pc_enable  = 1'b1;
            pc_select  = dec.pc_select;
            inc_select = dec.inc_select;
            link_we    = dec.link_we;
            state_nxt  = S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign bus.Mem_req    = mem_req;
   assign bus.IR_load    = ir_load;
   assign bus.PC_Reset   = pc_reset;
   assign bus.PC_enable  = pc_enable;
   assign bus.PC_select  = pc_select;
   assign bus.INC_select = inc_select;
   assign bus.Link_we    = link_we;
   assign bus.Halted     = halted;
   assign bus.Inst_count = cnt_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer with a behavioural PC datapath.
// Honours PROGRAM_SEQUENCER_LINK_EN for the CALL link expectation.
module tb_program_sequencer;
   import gamma_ctrl_pkg::*;

`ifdef PROGRAM_SEQUENCER_LINK_EN
   localparam logic LINK_EXP = 1'b1;
`else
   localparam logic LINK_EXP = 1'b0;
`endif

   localparam logic [15:0] OFFSET = 16'd5;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int vectors     = 0;
   int miscompares = 0;

   logic [15:0] pc;
   logic [15:0] pc_temp;
   logic [15:0] ra = 16'd0;
   int          cyc = 0;
   int          en_cnt = 0;
   int          last_upd = -1;

   program_sequencer_if #(.CNT_W(16)) bus ();
   program_sequencer_if #(.CNT_W(2))  wbus ();

   program_sequencer #(.CNT_W(16)) dut (
      .Clock (clk),
      .Reset (rst),
      .bus   (bus.master)
   );

   program_sequencer #(.CNT_W(2)) dut_w (
      .Clock (clk),
      .Reset (rst),
      .bus   (wbus.master)
   );

   always #5 clk = ~clk;

   // External PC datapath: PC_Reset clears, PC_enable loads the selected address.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.PC_enable) en_cnt <= en_cnt + 1;
      if (bus.PC_Reset) begin
         pc <= 16'd0;
      end else if (bus.PC_enable) begin
         pc_temp <= pc;
         if (bus.PC_select)
            pc <= pc + (bus.INC_select ? OFFSET : 16'd1);
         else
            pc <= ra;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Entry and exit at a negedge in FETCH; one full instruction.
   task automatic run_instr(input string tag, input logic [2:0] op, input logic c,
                            input int waits, input logic e_sel, input logic e_inc,
                            input logic e_link, input logic [15:0] e_pc);
      logic [15:0] pc0;
      pc0 = pc;
      bus.Mem_ready = 1'b0;
      for (int i = 0; i < waits; i++) begin
         #1;
         chk({tag, ".wait_req"}, 32'(bus.Mem_req), 32'd1);
         chk({tag, ".wait_irl"}, 32'(bus.IR_load), 32'd0);
         @(negedge clk);
      end
      if (waits > 0) chk({tag, ".wait_pc"}, 32'(pc), 32'(pc0));
      bus.Mem_ready = 1'b1;
      bus.Op_class  = op;
      bus.Cond_true = c;
      #1;
      chk({tag, ".ir_load"}, 32'(bus.IR_load), 32'd1);
      @(negedge clk);
      bus.Mem_ready = 1'b0;
      #1;
      chk({tag, ".dec_req"}, 32'(bus.Mem_req), 32'd0);
      chk({tag, ".dec_en"}, 32'(bus.PC_enable), 32'd0);
      @(negedge clk);
      bus.Op_class  = OP_HALT;
      bus.Cond_true = ~c;
      #1;
      chk({tag, ".pc_en"}, 32'(bus.PC_enable), 32'd1);
      chk({tag, ".pc_sel"}, 32'(bus.PC_select), 32'(e_sel));
      chk({tag, ".inc_sel"}, 32'(bus.INC_select), 32'(e_inc));
      chk({tag, ".link"}, 32'(bus.Link_we), 32'(e_link));
      if (last_upd >= 0) chk({tag, ".period"}, 32'(cyc - last_upd), 32'(waits + 3));
      last_upd = cyc;
      @(negedge clk);
      #1;
      chk({tag, ".pc"}, 32'(pc), 32'(e_pc));
      chk({tag, ".req"}, 32'(bus.Mem_req), 32'd1);
      chk({tag, ".sel_lo"}, 32'(bus.PC_select), 32'd0);
   endtask

   initial begin
      int e0;
      bus.Start      = 1'b0;
      bus.Mem_ready  = 1'b0;
      bus.Op_class   = 3'd0;
      bus.Cond_true  = 1'b0;
      wbus.Start     = 1'b0;
      wbus.Mem_ready = 1'b0;
      wbus.Op_class  = 3'd0;
      wbus.Cond_true = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst.pc_reset", 32'(bus.PC_Reset), 32'd1);
      chk("rst.req", 32'(bus.Mem_req), 32'd0);
      chk("rst.en", 32'(bus.PC_enable), 32'd0);
      chk("rst.halted", 32'(bus.Halted), 32'd0);
      chk("rst.link", 32'(bus.Link_we), 32'd0);
      chk("rst.sel", 32'(bus.PC_select), 32'd0);
      chk("rst.inc", 32'(bus.INC_select), 32'd0);
      chk("rst.cnt", 32'(bus.Inst_count), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle.hold", 32'(bus.PC_Reset), 32'd1);
      bus.Start = 1'b1;
      @(negedge clk);
      bus.Start = 1'b0;
      #1;
      chk("start.req", 32'(bus.Mem_req), 32'd1);
      chk("start.pcr", 32'(bus.PC_Reset), 32'd0);
      chk("start.pc", 32'(pc), 32'd0);

      // Sequential ALU ops
      run_instr("alu1", OP_ALU, 1'b0, 0, 1'b1, 1'b0, 1'b0, 16'd1);
      run_instr("alu2", OP_ALU, 1'b0, 0, 1'b1, 1'b0, 1'b0, 16'd2);
      run_instr("alu3", OP_ALU, 1'b0, 0, 1'b1, 1'b0, 1'b0, 16'd3);
      run_instr("alu4", OP_ALU, 1'b0, 0, 1'b1, 1'b0, 1'b0, 16'd4);
      chk("cnt4", 32'(bus.Inst_count), 32'd4);

      // Control-flow classes
      ra = 16'd10;
      run_instr("jr10", OP_JR, 1'b0, 0, 1'b0, 1'b0, 1'b0, 16'd10);
      run_instr("brc_nt", OP_BRC, 1'b0, 0, 1'b1, 1'b0, 1'b0, 16'd11);
      run_instr("brc_t", OP_BRC, 1'b1, 0, 1'b1, 1'b1, 1'b0, 16'd16);
      ra = 16'd40;
      run_instr("jr40", OP_JR, 1'b1, 0, 1'b0, 1'b0, 1'b0, 16'd40);
      run_instr("br", OP_BR, 1'b0, 0, 1'b1, 1'b1, 1'b0, 16'd45);
      run_instr("call", OP_CALL, 1'b0, 0, 1'b1, 1'b1, LINK_EXP, 16'd50);
      run_instr("op5", 3'd5, 1'b1, 0, 1'b1, 1'b0, 1'b0, 16'd51);
      run_instr("op6", 3'd6, 1'b1, 0, 1'b1, 1'b0, 1'b0, 16'd52);
      run_instr("wait5", OP_ALU, 1'b0, 5, 1'b1, 1'b0, 1'b0, 16'd53);
      chk("cnt13", 32'(bus.Inst_count), 32'd13);

      // HALT, Start ignored, Reset exits
      bus.Mem_ready = 1'b1;
      bus.Op_class  = OP_HALT;
      @(negedge clk);
      bus.Mem_ready = 1'b0;
      #1;
      chk("halt.dec", 32'(bus.Halted), 32'd0);
      @(negedge clk);
      #1;
      chk("halt.on", 32'(bus.Halted), 32'd1);
      chk("halt.req", 32'(bus.Mem_req), 32'd0);
      chk("halt.pcr", 32'(bus.PC_Reset), 32'd0);
      e0 = en_cnt;
      bus.Start = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("halt.stay", 32'(bus.Halted), 32'd1);
      chk("halt.no_en", 32'(en_cnt), 32'(e0));
      chk("halt.pc", 32'(pc), 32'd53);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("hrst.pcr", 32'(bus.PC_Reset), 32'd1);
      chk("hrst.halted", 32'(bus.Halted), 32'd0);
      chk("hrst.cnt", 32'(bus.Inst_count), 32'd0);
      @(negedge clk);
      #1;
      chk("hrst.start_lose", 32'(bus.Mem_req), 32'd0);
      rst = 1'b0;
      bus.Start = 1'b0;
      last_upd = -1;

      // Reset during FETCH with Mem_ready
      @(negedge clk);
      bus.Start = 1'b1;
      @(negedge clk);
      bus.Start = 1'b0;
      #1;
      chk("frst.req", 32'(bus.Mem_req), 32'd1);
      bus.Mem_ready = 1'b1;
      bus.Op_class  = OP_ALU;
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("frst.req_drop", 32'(bus.Mem_req), 32'd0);
      chk("frst.pcr", 32'(bus.PC_Reset), 32'd1);
      chk("frst.irl", 32'(bus.IR_load), 32'd0);
      rst = 1'b0;
      e0 = en_cnt;
      repeat (3) @(negedge clk);
      #1;
      chk("frst.no_upd", 32'(en_cnt), 32'(e0));
      chk("frst.idle", 32'(bus.Mem_req), 32'd0);
      chk("frst.cnt", 32'(bus.Inst_count), 32'd0);
      chk("frst.pc", 32'(pc), 32'd0);
      bus.Mem_ready = 1'b0;

      // Counter wrap on the narrow instance
      wbus.Mem_ready = 1'b1;
      wbus.Op_class  = OP_ALU;
      wbus.Start     = 1'b1;
      @(negedge clk);
      wbus.Start = 1'b0;
      repeat (9) @(negedge clk);
      #1;
      chk("wrap.max", 32'(wbus.Inst_count), 32'd3);
      repeat (3) @(negedge clk);
      #1;
      chk("wrap.zero", 32'(wbus.Inst_count), 32'd0);
      chk("wrap.main_idle", 32'(bus.Inst_count), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
